// File: rtl/mac_array_pkg.sv
// Shared MAC-array constants: FP8 field layout, common operand values, feeder states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mac_array_pkg;

  // Operand width (FP8)
  localparam int W = 8;

  // FP8 layout: sign[7], exp[6:4] bias 3, frac[3:0]
  localparam int FP8_SIGN    = 7;
  localparam int FP8_EXP_HI  = 6;
  localparam int FP8_EXP_LO  = 4;
  localparam int FP8_FRAC_HI = 3;
  localparam int FP8_FRAC_LO = 0;
  localparam int FP8_BIAS    = 3;

  localparam logic [W-1:0] FP8_ZERO = 8'h00;
  localparam logic [W-1:0] FP8_ONE  = 8'h30;
  localparam logic [W-1:0] FP8_TWO  = 8'h40;

  // Feeder sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Host-side load/start bus plus the skewed west/north operand lanes of the feeder.
// Latency: n/a (wiring only).
// Backpressure: none; the array consumes one vector per cycle unconditionally.
interface systolic_operand_feeder_if
  import mac_array_pkg::*;
#(
  parameter int N = 3
);
  localparam int LW = $clog2(N);

  logic          wr_en;
  logic          wr_sel;
  logic [LW-1:0] wr_row;
  logic [LW-1:0] wr_col;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [N*W-1:0] a_out;
  logic [N*W-1:0] b_out;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  a_out, b_out, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output a_out, b_out, busy, done
  );

endinterface

// File: rtl/skew_lane_select.sv
// Picks element (step - lane) of one matrix row/column, or FP8 zero outside the skew window.
// Latency: combinational.
// Backpressure: none.
module skew_lane_select
  import mac_array_pkg::*;
#(
  parameter int N  = 3,
  parameter int LW = $clog2(N),
  parameter int TW = $clog2(3*N-1)
) (
  input  logic [LW-1:0]         lane,
  input  logic [TW-1:0]         step,
  input  logic [N-1:0][W-1:0]   vec,
  output logic [W-1:0]          elem
);

  logic [TW:0] diff;
  logic        hit;

  // Element index is step - lane; the extra MSB flags step < lane
  always_comb begin
    diff = {1'b0, step} - {{(TW+1-LW){1'b0}}, lane};
    hit  = !diff[TW] && (diff[TW-1:0] < TW'(N));
    elem = FP8_ZERO;
    if (hit) begin
      elem = vec[diff[LW-1:0]];
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Stores NxN A/B FP8 matrices and streams them diagonally skewed onto the array's west/north edges.
// Latency: start sampled at edge c -> vector 0 in cycle c, done pulse in cycle c+3N-2+FLUSH.
// Backpressure: none; writes outside IDLE/DONE and starts while busy are dropped.
module systolic_operand_feeder
  import mac_array_pkg::*;
#(
  parameter int N     = 3,
  parameter int FLUSH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  systolic_operand_feeder_if.slave    io
);

  localparam int LW   = $clog2(N);
  localparam int TW   = $clog2(3*N-1);
  localparam int FW   = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam int LAST = 3*N-3;

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

  mat_t           a_mem_q, a_mem_d;
  mat_t           b_mem_q, b_mem_d;
  mat_t           b_cols;
  feed_state_e    state_q, state_d;
  logic [TW-1:0]  t_q, t_d, sel_t;
  logic [FW-1:0]  fl_q, fl_d;
  logic [N*W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic [N*W-1:0] a_lanes, b_lanes;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           wr_ok;

  // Write decode; lane selection reads the post-write image so a write alongside start is streamed
  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    wr_ok   = io.wr_en && (state_q == ST_IDLE || state_q == ST_DONE)
              && (32'(io.wr_row) < N) && (32'(io.wr_col) < N);
    if (wr_ok) begin
      if (io.wr_sel) b_mem_d[io.wr_row][io.wr_col] = io.wr_data;
      else           a_mem_d[io.wr_row][io.wr_col] = io.wr_data;
    end
  end

  // Transpose B so each north lane sees one column as a contiguous vector
  always_comb begin
    b_cols = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        b_cols[j][k] = b_mem_d[k][j];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane_select #(.N(N), .LW(LW), .TW(TW)) u_a_sel (
      .lane (LW'(i)),
      .step (sel_t),
      .vec  (a_mem_d[i]),
      .elem (a_lanes[i*W +: W])
    );
    skew_lane_select #(.N(N), .LW(LW), .TW(TW)) u_b_sel (
      .lane (LW'(i)),
      .step (sel_t),
      .vec  (b_cols[i]),
      .elem (b_lanes[i*W +: W])
    );
  end

  // Sequencer: next state, step/flush counters and next lane contents
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    fl_d    = fl_q;
    sel_t   = '0;
    a_out_d = '0;
    b_out_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          state_d = ST_FEED;
          t_d     = '0;
          a_out_d = a_lanes;
          b_out_d = b_lanes;
          busy_d  = 1'b1;
        end
      end
      ST_FEED: begin
        busy_d = 1'b1;
        if (t_q == TW'(LAST)) begin
          state_d = ST_FLUSH;
          fl_d    = '0;
        end else begin
          sel_t   = t_q + TW'(1);
          t_d     = sel_t;
          a_out_d = a_lanes;
          b_out_d = b_lanes;
        end
      end
      ST_FLUSH: begin
        if (fl_q == FW'(FLUSH-1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          fl_d   = fl_q + FW'(1);
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, storage and registered outputs; reset also clears both matrices
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      fl_q    <= '0;
      a_mem_q <= '0;
      b_mem_q <= '0;
      a_out_q <= '0;
      b_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      fl_q    <= fl_d;
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io.a_out = a_out_q;
  assign io.b_out = b_out_q;
  assign io.busy  = busy_q;
  assign io.done  = done_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Scoreboard bench for the operand feeder: cycle-tagged expected lanes and done pulses.
// Latency: n/a.
// Backpressure: n/a.
module tb_systolic_operand_feeder;
  import mac_array_pkg::*;

  localparam int N     = 3;
  localparam int FLUSH = 2;
  localparam int NW    = N*W;
  localparam int LW    = $clog2(N);
  localparam int NV    = 3*N-2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_operand_feeder_if #(.N(N)) io ();

  systolic_operand_feeder #(.N(N), .FLUSH(FLUSH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    int            cyc;
    logic [NW-1:0] a;
    logic [NW-1:0] b;
  } exp_t;

  exp_t       exp_q[$];
  int         done_q[$];
  exp_t       mon_e;
  logic [W-1:0] ma[N][N];
  logic [W-1:0] mb[N][N];
  int         cyc   = 0;
  int         n_vec = 0;
  int         n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [NW-1:0] lanes_a(input int t);
    logic [NW-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*W +: W] = ma[i][t-i];
    return r;
  endfunction

  function automatic logic [NW-1:0] lanes_b(input int t);
    logic [NW-1:0] r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*W +: W] = mb[t-j][j];
    return r;
  endfunction

  task automatic push_run(input int c);
    exp_t e;
    for (int t = 0; t < NV; t++) begin
      e.cyc = c + t; e.a = lanes_a(t); e.b = lanes_b(t);
      exp_q.push_back(e);
    end
    for (int f = 0; f < FLUSH; f++) begin
      e.cyc = c + NV + f; e.a = '0; e.b = '0;
      exp_q.push_back(e);
    end
    done_q.push_back(c + NV + FLUSH);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = FP8_ZERO;
        mb[i][j] = FP8_ZERO;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic sel, input int row, input int col, input logic [W-1:0] d,
                    input logic accept);
    io.wr_en   = 1'b1;
    io.wr_sel  = sel;
    io.wr_row  = LW'(row);
    io.wr_col  = LW'(col);
    io.wr_data = d;
    tick();
    io.wr_en = 1'b0;
    if (accept) begin
      if (sel) mb[row][col] = d;
      else     ma[row][col] = d;
    end
  endtask

  // Raise start, record the sampling edge and queue the expected run; start stays high if keep
  task automatic launch(output int c, input logic keep);
    io.start = 1'b1;
    @(posedge clk);
    #1;
    c = cyc;
    push_run(c);
    #1;
    if (!keep) io.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && done_q.size() == 0) break;
      tick();
    end
    chk("drain", 64'(exp_q.size() + done_q.size()), 64'd0);
  endtask

  // Monitor: busy cycles pop the scoreboard; idle cycles must show zero lanes
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (io.busy) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("vec_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("a_out", 64'(io.a_out), 64'(mon_e.a));
          chk("b_out", 64'(io.b_out), 64'(mon_e.b));
        end
      end else begin
        chk("idle_lanes", 64'({io.a_out, io.b_out}), 64'd0);
      end
      if (io.done) begin
        if (done_q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
        else                    chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        chk("busy_at_done", 64'(io.busy), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    io.wr_en = 1'b0; io.wr_sel = 1'b0; io.wr_row = '0; io.wr_col = '0;
    io.wr_data = '0; io.start = 1'b0;
    clear_model();
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_a_out", 64'(io.a_out), 64'd0);
    chk("rst_b_out", 64'(io.b_out), 64'd0);
    chk("rst_busy",  64'(io.busy), 64'd0);
    chk("rst_done",  64'(io.done), 64'd0);
    rst = 1'b0;
    tick();

    // Uniform operands: A=1.0, B=2.0 everywhere
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        wr(1'b0, i, j, FP8_ONE, 1'b1);
        wr(1'b1, i, j, FP8_TWO, 1'b1);
      end
    launch(c, 1'b0);
    chk("busy_first_cycle", 64'(io.busy), 64'd1);
    wait_idle();

    // Distinct values expose any index swap
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        wr(1'b0, i, j, 8'(16*i + j + 1), 1'b1);
        wr(1'b1, i, j, 8'(8'h80 + 16*j + i + 1), 1'b1);
      end
    launch(c, 1'b0);
    wait_idle();

    // Write during FEED is dropped
    launch(c, 1'b0);
    tick();
    wr(1'b0, 1, 1, 8'h55, 1'b0);
    wait_idle();

    // Out-of-range indices in IDLE are dropped; next run streams old contents
    wr(1'b0, 3, 1, 8'h77, 1'b0);
    wr(1'b1, 1, 3, 8'h66, 1'b0);
    launch(c, 1'b0);
    wait_idle();

    // Write and start in the same cycle: the write is visible in vector 0
    io.wr_en = 1'b1; io.wr_sel = 1'b0; io.wr_row = '0; io.wr_col = '0; io.wr_data = 8'h11;
    ma[0][0] = 8'h11;
    launch(c, 1'b0);
    io.wr_en = 1'b0;
    wait_idle();

    // start pulsed mid-FEED is ignored
    launch(c, 1'b0);
    tick();
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    wait_idle();

    // start held high: back-to-back runs with one IDLE cycle between
    launch(c, 1'b1);
    for (int k = 0; k < 40; k++) begin
      if (cyc >= c + NV + FLUSH + 2) break;
      tick();
    end
    chk("rerun_cycle", 64'(cyc), 64'(c + NV + FLUSH + 2));
    push_run(c + NV + FLUSH + 2);
    io.start = 1'b0;
    wait_idle();

    // Reset mid-FEED: lanes drop, no done, storage cleared
    launch(c, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    clear_model();
    tick();
    chk("midrst_a_out", 64'(io.a_out), 64'd0);
    chk("midrst_b_out", 64'(io.b_out), 64'd0);
    chk("midrst_busy",  64'(io.busy), 64'd0);
    chk("midrst_done",  64'(io.done), 64'd0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    launch(c, 1'b0);
    wait_idle();

    tick();
    chk("sb_leftover", 64'(exp_q.size() + done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
